serial_twos_comp_framed: RTL and testbench
==========================================

# serial_twos_comp_framed

Parametrised, word-framed successor to the team's bit-serial two's complementer. Accepts a W-bit word LSB-first, one bit per accepted cycle, and emits either the word unchanged or its two's complement, bit-serially with one cycle of latency. It adds a valid handshake with stalls, per-word mode selection, word framing and resync, and end-of-word status flags (zero, overflow, frame error). It sits between a serial source and a serial sink in the arithmetic datapath.

## Interface
- W, default 8: word width in bits; legal range W >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  incode/in_first/mode are valid this cycle; a bit is accepted whenever in_valid=1 (there is no backpressure).
- in_first  input  1  marks bit 0 (LSB) of a word; optional, used for resync.
- incode  input  1  serial data bit.
- mode  input  1  0 = pass-through, 1 = negate; sampled only on bit 0 of a word.
- out_valid  output  1  outcode is valid.
- outcode  output  1  serial result bit.
- out_last  output  1  outcode is bit W-1 of the word.
- seen_one  output  1  a 1 has been accepted in the current word, up to and including the bit now on outcode.
- zero  output  1  the input word was all zeros; valid with out_last.
- ovf  output  1  negate mode and the input word was 1 followed by W-1 zeros (most negative value); valid with out_last.
- frame_err  output  1  single-cycle pulse: in_first arrived mid-word.

## Operation
- State machine:
  - IDLE: waiting for bit 0.
  - COPY: no 1 seen yet in the current word.
  - INV: a 1 has been seen.
- Bit index counter idx, width $clog2(W), counts 0..W-1. It advances only on accepted bits.
- On an accepted bit b at index idx:
  - Bit 0 latches mode into mode_q.
  - mode_q=0: out = b. The state is still tracked so that zero and seen_one remain valid.
  - mode_q=1, state COPY or IDLE: out = b.
  - mode_q=1, state INV: out = ~b.
  - If b=1 in IDLE or COPY, the next state is INV; otherwise the state is held.
  - If idx=W-1: out_last=1, idx returns to 0 and the state returns to IDLE.
- Word status at bit W-1, using the pre-update state:
  - zero=1 if the state is COPY and b=0.
  - ovf=1 if mode_q=1, the state is COPY and b=1.
  - Both flags are 0 on all other cycles.
- Resync: in_first=1 with idx!=0 on an accepted bit:
  - frame_err pulses.
  - The partial word is abandoned; its already-emitted bits stand, and no out_last is emitted for it.
  - This bit is treated as bit 0 of a new word: mode is latched and the state restarts from IDLE.
- in_first=1 with idx=0 is normal and produces no flag. in_first=0 with idx=0 is still accepted as bit 0.
- in_first, incode and mode are ignored while in_valid=0.
- W=2: COPY/INV still apply. The only word with ovf set is 2'b10.

## Timing
- All outputs are registered. The bit accepted at edge N appears on outputs after edge N, valid during cycle N+1.
- Latency is 1 cycle; throughput is 1 bit per cycle.
- out_valid mirrors in_valid delayed by one cycle.
- When out_valid=0, outcode, out_last, zero, ovf and frame_err are 0. seen_one holds its last value.
- Stalls (in_valid=0) freeze idx, state and mode_q indefinitely.
- Back-to-back words: bit W-1 of word k and bit 0 of word k+1 may arrive on consecutive cycles with no bubble. mode may change at that boundary.
- Reset, also mid-word: on the edge where rst=1, the state goes to IDLE and idx, mode_q and all outputs go to 0. The partial word is discarded, with no flags. The first accepted bit after rst deasserts is bit 0.
- rst has priority over in_valid in the same cycle.

## Test plan
- W=8, mode=1, word 8'b00000101 fed contiguously -> output 8'b11111011 LSB-first; seen_one rises on the output of bit 0; out_last on the 8th output; zero=0, ovf=0.
- mode=0, word 8'h05, then mode=1, word 8'h80 back-to-back -> outputs 8'h05, then 8'h80 with ovf=1 on the second out_last only.
- mode=1, word 8'h00 -> output 8'h00, zero=1 and ovf=0 at out_last, seen_one=0 throughout.
- mode=1, word 8'h2C with in_valid low for 3 cycles after bit 2 and 1 cycle after bit 5 -> output 8'hD4 with the same gaps, one cycle later; no spurious out_valid.
- Word started, then in_first=1 on the 4th accepted bit, followed by an 8-bit word 8'h01 in mode=1 -> frame_err pulses once; no out_last for the aborted word; the new word yields 8'hFF.
- rst=1 after 5 bits of a word, then a full word 8'h7F in mode=1 -> all outputs 0 in the cycle after reset; result 8'h81 with correct out_last timing.

Source files
------------

// File: rtl/serial_twos_comp_framed.sv
// Word-framed bit-serial two's complementer, LSB first.
// One cycle of latency, valid-only handshake, resync on in_first.
module serial_twos_comp_framed #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_first,
    input  logic incode,
    input  logic mode,
    output logic out_valid,
    output logic outcode,
    output logic out_last,
    output logic seen_one,
    output logic zero,
    output logic ovf,
    output logic frame_err
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        INV  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            mode_q, mode_d;

    logic            out_valid_q, out_valid_d;
    logic            outcode_q, outcode_d;
    logic            out_last_q, out_last_d;
    logic            seen_one_q, seen_one_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            frame_err_q, frame_err_d;

    logic            resync;
    logic            bit0;
    logic            last;
    logic            eff_mode;
    state_t          cur;

    // Decode the position of the incoming bit within its word
    always_comb begin
        resync   = in_valid & in_first & (idx_q != '0);
        bit0     = (idx_q == '0) | resync;
        last     = ~resync & (idx_q == IDX_LAST);
        eff_mode = bit0 ? mode : mode_q;
        cur      = bit0 ? IDLE : state_q;
    end

    // State, index and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Next state: advance only on accepted bits, wrap at the word end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        if (in_valid) begin
            mode_d = eff_mode;
            if (last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = bit0 ? IW'(1) : idx_q + IW'(1);
                state_d = (cur == INV || incode) ? INV : COPY;
            end
        end
    end

    // Output values for the bit being accepted this cycle
    always_comb begin
        out_valid_d = in_valid;
        outcode_d   = in_valid & (incode ^ (eff_mode & (cur == INV)));
        out_last_d  = in_valid & last;
        zero_d      = in_valid & last & (cur == COPY) & ~incode;
        ovf_d       = in_valid & last & eff_mode & (cur == COPY) & incode;
        frame_err_d = resync;
        seen_one_d  = seen_one_q;
        if (in_valid) begin
            seen_one_d = incode | (cur == INV);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            outcode_q   <= 1'b0;
            out_last_q  <= 1'b0;
            seen_one_q  <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            outcode_q   <= outcode_d;
            out_last_q  <= out_last_d;
            seen_one_q  <= seen_one_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign outcode   = outcode_q;
    assign out_last  = out_last_q;
    assign seen_one  = seen_one_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_twos_comp_framed.sv
// Directed bench for serial_twos_comp_framed, W=8.
// Each task drives one scenario and checks its own hand-computed results.
module tb_serial_twos_comp_framed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic incode = 1'b0;
    logic mode = 1'b0;
    logic out_valid, outcode, out_last, seen_one, zero, ovf, frame_err;

    int checks = 0;
    int failures = 0;

    serial_twos_comp_framed #(.W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_first(in_first),
        .incode(incode),
        .mode(mode),
        .out_valid(out_valid),
        .outcode(outcode),
        .out_last(out_last),
        .seen_one(seen_one),
        .zero(zero),
        .ovf(ovf),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // One cycle: drive at negedge, sample 1 time unit after the posedge
    task automatic step(input logic v, input logic f, input logic b, input logic m);
        @(negedge clk);
        in_valid = v;
        in_first = f;
        incode   = b;
        mode     = m;
        @(posedge clk);
        #1;
    endtask

    // Feed one contiguous word; mode is inverted on bits 1..7 to prove it is ignored there
    task automatic run_word(input logic [7:0] w, input logic m, input logic f,
                            output logic [7:0] res, output logic [7:0] lv,
                            output logic [7:0] zv, output logic [7:0] ov,
                            output logic [7:0] sv, output logic [7:0] fv,
                            output logic [7:0] vv);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? f : 1'b0, w[i], (i == 0) ? m : ~m);
            res[i] = outcode;
            lv[i]  = out_last;
            zv[i]  = zero;
            ov[i]  = ovf;
            sv[i]  = seen_one;
            fv[i]  = frame_err;
            vv[i]  = out_valid;
        end
    endtask

    task automatic test_reset;
        logic [6:0] o;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        o = {out_valid, outcode, out_last, seen_one, zero, ovf, frame_err};
        checks++;
        if (o !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", o, 7'b0);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        o = {out_valid, outcode, out_last, seen_one, zero, ovf, frame_err};
        checks++;
        if (o !== 7'b0) begin
            failures++;
            $display("FAIL idle_outputs got=%b exp=%b", o, 7'b0);
        end
    endtask

    task automatic test_negate;
        logic [7:0] r, l, z, ov, s, f, v;
        run_word(8'h05, 1'b1, 1'b1, r, l, z, ov, s, f, v);
        checks++;
        if (r !== 8'hFB) begin
            failures++;
            $display("FAIL negate_05 got=%h exp=%h", r, 8'hFB);
        end
        checks++;
        if (v !== 8'hFF) begin
            failures++;
            $display("FAIL negate_valid got=%h exp=%h", v, 8'hFF);
        end
        checks++;
        if (s !== 8'hFF) begin
            failures++;
            $display("FAIL negate_seen got=%h exp=%h", s, 8'hFF);
        end
        checks++;
        if (l !== 8'h80) begin
            failures++;
            $display("FAIL negate_last got=%h exp=%h", l, 8'h80);
        end
        checks++;
        if ({z, ov, f} !== 24'h0) begin
            failures++;
            $display("FAIL negate_flags got=%h exp=%h", {z, ov, f}, 24'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r1, l1, z1, o1, s1, f1, v1;
        logic [7:0] r2, l2, z2, o2, s2, f2, v2;
        run_word(8'h05, 1'b0, 1'b1, r1, l1, z1, o1, s1, f1, v1);
        run_word(8'h80, 1'b1, 1'b0, r2, l2, z2, o2, s2, f2, v2);
        checks++;
        if (r1 !== 8'h05) begin
            failures++;
            $display("FAIL b2b_pass got=%h exp=%h", r1, 8'h05);
        end
        checks++;
        if (o1 !== 8'h00) begin
            failures++;
            $display("FAIL b2b_ovf1 got=%h exp=%h", o1, 8'h00);
        end
        checks++;
        if (r2 !== 8'h80) begin
            failures++;
            $display("FAIL b2b_neg80 got=%h exp=%h", r2, 8'h80);
        end
        checks++;
        if (o2 !== 8'h80) begin
            failures++;
            $display("FAIL b2b_ovf2 got=%h exp=%h", o2, 8'h80);
        end
        checks++;
        if ({l1, l2} !== 16'h8080) begin
            failures++;
            $display("FAIL b2b_last got=%h exp=%h", {l1, l2}, 16'h8080);
        end
        checks++;
        if (s2 !== 8'h80) begin
            failures++;
            $display("FAIL b2b_seen got=%h exp=%h", s2, 8'h80);
        end
    endtask

    task automatic test_zero;
        logic [7:0] r, l, z, ov, s, f, v;
        run_word(8'h00, 1'b1, 1'b1, r, l, z, ov, s, f, v);
        checks++;
        if (r !== 8'h00) begin
            failures++;
            $display("FAIL zero_data got=%h exp=%h", r, 8'h00);
        end
        checks++;
        if (z !== 8'h80) begin
            failures++;
            $display("FAIL zero_flag got=%h exp=%h", z, 8'h80);
        end
        checks++;
        if ({ov, s} !== 16'h0) begin
            failures++;
            $display("FAIL zero_ovf_seen got=%h exp=%h", {ov, s}, 16'h0);
        end
    endtask

    task automatic test_stall;
        logic [7:0] w;
        logic [7:0] r;
        logic [7:0] l;
        int bi;
        int bad;
        // 1 = accepted bit, 0 = bubble: b0 b1 b2 - - - b3 b4 b5 - b6 b7
        logic [11:0] pat;
        w   = 8'h2C;
        pat = 12'b110111000111;
        bi  = 0;
        bad = 0;
        r   = 8'h00;
        l   = 8'h00;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            if (pat[c]) begin
                step(1'b1, bi == 0, w[bi], (bi == 0) ? 1'b1 : 1'b0);
                if (out_valid !== 1'b1) bad++;
                r[bi] = outcode;
                l[bi] = out_last;
                bi++;
            end else begin
                step(1'b0, 1'b1, 1'b1, 1'b0);
                if ({out_valid, outcode, out_last, frame_err} !== 4'b0) bad++;
            end
        end
        checks++;
        if (r !== 8'hD4) begin
            failures++;
            $display("FAIL stall_data got=%h exp=%h", r, 8'hD4);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_valid bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (l !== 8'h80) begin
            failures++;
            $display("FAIL stall_last got=%h exp=%h", l, 8'h80);
        end
    endtask

    task automatic test_resync;
        logic [7:0] r, l, z, ov, s, f, v;
        logic [2:0] pl, pf;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        pl[0] = out_last;
        pf[0] = frame_err;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pl[1] = out_last;
        pf[1] = frame_err;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        pl[2] = out_last;
        pf[2] = frame_err;
        run_word(8'h01, 1'b1, 1'b1, r, l, z, ov, s, f, v);
        checks++;
        if ({pl, pf} !== 6'b0) begin
            failures++;
            $display("FAIL resync_partial got=%b exp=%b", {pl, pf}, 6'b0);
        end
        checks++;
        if (f !== 8'h01) begin
            failures++;
            $display("FAIL resync_frame_err got=%h exp=%h", f, 8'h01);
        end
        checks++;
        if (r !== 8'hFF) begin
            failures++;
            $display("FAIL resync_data got=%h exp=%h", r, 8'hFF);
        end
        checks++;
        if (l !== 8'h80) begin
            failures++;
            $display("FAIL resync_last got=%h exp=%h", l, 8'h80);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] r, l, z, ov, s, f, v;
        logic [6:0] o;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        o = {out_valid, outcode, out_last, seen_one, zero, ovf, frame_err};
        checks++;
        if (o !== 7'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=%b", o, 7'b0);
        end
        rst = 1'b0;
        run_word(8'h7F, 1'b1, 1'b0, r, l, z, ov, s, f, v);
        checks++;
        if (r !== 8'h81) begin
            failures++;
            $display("FAIL midrst_data got=%h exp=%h", r, 8'h81);
        end
        checks++;
        if (l !== 8'h80) begin
            failures++;
            $display("FAIL midrst_last got=%h exp=%h", l, 8'h80);
        end
        checks++;
        if ({f, z, ov} !== 24'h0) begin
            failures++;
            $display("FAIL midrst_flags got=%h exp=%h", {f, z, ov}, 24'h0);
        end
    endtask

    initial begin
        test_reset;
        test_negate;
        test_back_to_back;
        test_zero;
        test_stall;
        test_resync;
        test_reset_mid;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
